shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Load sequencer for the bidirectional shift register (`bidir_shift_reg`). It accepts a parallel word on a start pulse and drives the register's `dir` and `serial_in` for exactly N cycles, so the register holds the word afterwards. It sits between a parallel-word producer and the shift register, and reports completion with a one-cycle `done` pulse.

## Interface
- `N`, default 4: shift register width; legal values N ≥ 2.
- `clk`  in  1  rising-edge clock, shared with the shift register.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a load; sampled only in IDLE.
- `word`  in  N  word to load; captured on the accepting edge.
- `order`  in  1  0 = shift right (LSB fed first), 1 = shift left (MSB fed first); captured with `word`.
- `q_in`  in  N  shift register `q`; used only when `SHIFT_SEQ_CHECK_EN` is defined.
- `busy`  out  1  high from the cycle after acceptance until `done` has been asserted.
- `done`  out  1  one-cycle completion pulse.
- `shift_en`  out  1  high during LOAD; gates an enable-capable register.
- `dir`  out  1  connects to shift register `dir`.
- `sr_serial_in`  out  1  connects to shift register `serial_in`.
- `err`  out  1  check mismatch flag; held at 0 when the check is compiled out.

## Operation
- State machine: IDLE → LOAD → (CHECK) → DONE → IDLE.
- IDLE:
  - `start` = 1 on an edge captures `word` into the data shadow and the check copy.
  - The same edge captures `order` into a register that drives `dir`.
  - The counter is cleared and the next state is LOAD.
- LOAD:
  - `shift_en` = 1.
  - `sr_serial_in` = `order` ? shadow[N-1] : shadow[0].
  - Each edge shifts the shadow toward the consumed end and increments the counter.
  - After N edges the next state is CHECK when `SHIFT_SEQ_CHECK_EN` is defined, otherwise DONE.
- Bit ordering:
  - Shift right (dir = 0) enters at q[N-1], so the LSB goes first.
  - Shift left (dir = 1) enters at q[0], so the MSB goes first.
  - After N edges, q equals `word` in both orders.
- CHECK: lasts one cycle. On its exit edge, `err` is set to (`q_in` != `word` copy).
- DONE: lasts one cycle with `done` = 1, then the next state is IDLE.
- `start` outside IDLE is ignored, including during the DONE cycle. There is no queueing.
- `dir` holds its last captured value in IDLE. `sr_serial_in` = 0 outside LOAD.
- Counter width is $clog2(N+1). There is no wrap: the counter is cleared on acceptance.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`, `done`, `shift_en`, `dir`, `sr_serial_in`, `err` all 0.
  - Shadow and counter = 0.
- Let the accepting edge be E0.
  - LOAD occupies the cycles after E0 through E(N).
  - Without check: `done` is high in the cycle after E(N). Latency start→done = N+1 cycles.
  - With check: CHECK is the cycle after E(N), and `done` is high in the cycle after that. Latency = N+2 cycles.
- `busy` = (state != IDLE). It is deasserted in the cycle following the `done` cycle.
- `err` is sticky and valid from the `done` cycle onward. It is cleared on the next accepting edge.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs 0.
  - No `done` pulse is produced.
  - The partial contents of the external register are not restored.
- All outputs are decoded from registered state and shadow only. There is no combinational path from `start`.

## Configuration
- `SHIFT_SEQ_CHECK_EN` defined:
  - The CHECK state is present and `q_in` is compared against the captured word.
  - `err` reports a mismatch.
- `SHIFT_SEQ_CHECK_EN` undefined:
  - There is no CHECK state and `q_in` is unused.
  - `err` is constant 0 and latency is N+1.

## Test plan
- N=4, `word`=4'b1011, `order`=0, single `start`:
  - `sr_serial_in` = 1,1,0,1 over 4 LOAD cycles with `dir`=0.
  - The model register ends at 1011.
  - `done` pulses in cycle 5 (no check) or cycle 6 (check).
- `word`=4'b1011, `order`=1:
  - `sr_serial_in` = 1,0,1,1 with `dir`=1.
  - The register ends at 1011.
- `start` held high throughout:
  - A new load is accepted only from IDLE.
  - There is exactly one `done` per load, and a one-cycle IDLE gap between loads.
- `reset` pulled low in the second LOAD cycle:
  - All outputs are 0 immediately and no `done` follows.
  - After release, a fresh `start` completes normally.
- With `SHIFT_SEQ_CHECK_EN`:
  - `q_in` tied to the register gives `err`=0.
  - `q_in` forced to 4'b0000 with `word`=4'b1011 gives `err`=1 at `done`.
  - The next accepted `start` clears `err`.
- N=8, `word`=8'hA5 in both orders: the register ends at A5, with latency N+1 (or N+2 with the check).

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serialises a captured parallel word into an external bidirectional shift register over N cycles.
// Define SHIFT_SEQ_CHECK_EN to add a one-cycle CHECK state that compares q_in against the captured word.
module shift_seq_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] word,
    input  logic         order,
    input  logic [N-1:0] q_in,
    output logic         busy,
    output logic         done,
    output logic         shift_en,
    output logic         dir,
    output logic         sr_serial_in,
    output logic         err
);
    localparam int CW = $clog2(N + 1);

`ifdef SHIFT_SEQ_CHECK_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
    localparam state_t AFTER_LOAD = CHECK;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam state_t AFTER_LOAD = DONE;
`endif

    state_t        state_reg, state_next;
    logic [N-1:0]  shadow_reg;
    logic [CW-1:0] cnt_reg;
    logic          dir_reg;
    logic          accept;
    logic          err_reg;

    assign accept = (state_reg == IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // The shadow moves toward the end being consumed, so the outgoing bit is always at a fixed position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_reg <= '0;
            cnt_reg    <= '0;
            dir_reg    <= 1'b0;
        end else if (accept) begin
            shadow_reg <= word;
            cnt_reg    <= '0;
            dir_reg    <= order;
        end else if (state_reg == LOAD) begin
            shadow_reg <= dir_reg ? {shadow_reg[N-2:0], 1'b0} : {1'b0, shadow_reg[N-1:1]};
            cnt_reg    <= cnt_reg + CW'(1);
        end
    end

`ifdef SHIFT_SEQ_CHECK_EN
    logic [N-1:0] copy_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            copy_reg <= '0;
            err_reg  <= 1'b0;
        end else if (accept) begin
            copy_reg <= word;
            err_reg  <= 1'b0;
        end else if (state_reg == CHECK) begin
            err_reg  <= (q_in != copy_reg);
        end
    end
`else
    logic unused_q;
    assign unused_q = ^q_in;
    assign err_reg  = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (cnt_reg == CW'(N - 1)) state_next = AFTER_LOAD;
`ifdef SHIFT_SEQ_CHECK_EN
            CHECK:   state_next = DONE;
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_reg != IDLE);
        done         = (state_reg == DONE);
        shift_en     = (state_reg == LOAD);
        dir          = dir_reg;
        sr_serial_in = 1'b0;
        if (state_reg == LOAD)
            sr_serial_in = dir_reg ? shadow_reg[N-1] : shadow_reg[0];
        err          = err_reg;
    end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl: N=4 and N=8 instances, each feeding a model of the external shift register.
module tb_shift_seq_ctrl;
`ifdef SHIFT_SEQ_CHECK_EN
    localparam int CE = 1;
`else
    localparam int CE = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start4, order4, zero_q;
    logic [3:0] word4, qin4;
    logic [3:0] q4 = 4'h0;
    logic       busy4, done4, shift_en4, dir4, sin4, err4;
    logic       start8, order8;
    logic [7:0] word8;
    logic [7:0] q8 = 8'h00;
    logic       busy8, done8, shift_en8, dir8, sin8, err8;

    int n_checks = 0;
    int n_pass   = 0;

    assign qin4 = zero_q ? 4'h0 : q4;

    shift_seq_ctrl #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .word(word4), .order(order4), .q_in(qin4),
        .busy(busy4), .done(done4), .shift_en(shift_en4), .dir(dir4), .sr_serial_in(sin4), .err(err4)
    );

    shift_seq_ctrl #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .word(word8), .order(order8), .q_in(q8),
        .busy(busy8), .done(done8), .shift_en(shift_en8), .dir(dir8), .sr_serial_in(sin8), .err(err8)
    );

    // External bidirectional shift registers: dir=0 enters at MSB, dir=1 enters at LSB.
    always @(posedge clk) begin
        if (shift_en4) q4 <= dir4 ? {q4[2:0], sin4} : {sin4, q4[3:1]};
        if (shift_en8) q8 <= dir8 ? {q8[6:0], sin8} : {sin8, q8[7:1]};
    end

    function automatic logic [5:0] outs(input bit big);
        return big ? {busy8, done8, shift_en8, dir8, sin8, err8}
                   : {busy4, done4, shift_en4, dir4, sin4, err4};
    endfunction

    task automatic drive(input bit big, input logic st, input logic [7:0] w, input logic ord);
        if (big) begin
            start8 = st; word8 = w; order8 = ord;
        end else begin
            start4 = st; word4 = w[3:0]; order4 = ord;
        end
    endtask

    // One complete load, checked cycle by cycle against the expected serial stream and timing.
    task automatic run_load(input bit big, input logic [7:0] w, input logic ord, input logic exp_err);
        int n;
        logic [5:0] exp;
        logic [7:0] qm, qw;
        n = big ? 8 : 4;
        @(negedge clk);
        drive(big, 1'b1, w, ord);
        @(negedge clk);
        drive(big, 1'b0, 8'($urandom), 1'($urandom));
        for (int k = 0; k < n; k++) begin
            exp = {1'b1, 1'b0, 1'b1, ord, (ord ? w[n-1-k] : w[k]), 1'b0};
            n_checks++;
            if (outs(big) !== exp)
                $display("FAIL load_cycle n=%0d k=%0d got %b want %b", n, k, outs(big), exp);
            else n_pass++;
            @(negedge clk);
        end
        if (CE == 1) begin
            exp = {1'b1, 1'b0, 1'b0, ord, 1'b0, 1'b0};
            n_checks++;
            if (outs(big) !== exp) $display("FAIL check_cycle got %b want %b", outs(big), exp);
            else n_pass++;
            @(negedge clk);
        end
        exp = {1'b1, 1'b1, 1'b0, ord, 1'b0, exp_err};
        n_checks++;
        if (outs(big) !== exp) $display("FAIL done_cycle n=%0d got %b want %b", n, outs(big), exp);
        else n_pass++;
        qm = big ? q8 : {4'h0, q4};
        qw = big ? w : {4'h0, w[3:0]};
        n_checks++;
        if (qm !== qw) $display("FAIL reg_contents n=%0d got %h want %h", n, qm, qw);
        else n_pass++;
        @(negedge clk);
        exp = {1'b0, 1'b0, 1'b0, ord, 1'b0, exp_err};
        n_checks++;
        if (outs(big) !== exp) $display("FAIL idle_after n=%0d got %b want %b", n, outs(big), exp);
        else n_pass++;
        $display("load n=%0d word=%h order=%0d reg=%h err=%0d", n, qw, ord, qm, outs(big) & 6'b1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (outs(0) !== 6'b0) $display("FAIL reset_n4 got %b want 000000", outs(0));
        else n_pass++;
        n_checks++;
        if (outs(1) !== 6'b0) $display("FAIL reset_n8 got %b want 000000", outs(1));
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic;
        run_load(0, 8'h0B, 1'b0, 1'b0);
        run_load(0, 8'h0B, 1'b1, 1'b0);
    endtask

    task automatic test_n8;
        run_load(1, 8'hA5, 1'b0, 1'b0);
        run_load(1, 8'hA5, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            bit big;
            logic [7:0] w;
            big = 1'($urandom);
            w = 8'($urandom);
            if (!big) w = w & 8'h0F;
            run_load(big, w, 1'($urandom), 1'b0);
        end
    endtask

    // start held high: loads repeat with period N+2(+check), one IDLE cycle between them.
    task automatic test_back_to_back;
        int p, period;
        logic [7:0] w;
        logic ord;
        logic [1:0] exp;
        period = 4 + CE + 2;
        w = 8'($urandom) & 8'h0F;
        ord = 1'($urandom);
        @(negedge clk);
        drive(0, 1'b1, w, ord);
        @(negedge clk);
        for (int t = 1; t <= 3 * period; t++) begin
            p = (t - 1) % period;
            exp = {(p != period - 1), (p == 4 + CE)};
            n_checks++;
            if ({busy4, done4} !== exp)
                $display("FAIL back_to_back t=%0d busy_done got %b want %b", t, {busy4, done4}, exp);
            else n_pass++;
            if (p == 4 + CE) begin
                n_checks++;
                if (q4 !== w[3:0]) $display("FAIL back_to_back_reg got %h want %h", q4, w[3:0]);
                else n_pass++;
                $display("back_to_back load done word=%h order=%0d reg=%h", w[3:0], ord, q4);
            end
            if (t == 3 * period) start4 = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (busy4 !== 1'b0) $display("FAIL back_to_back_stop busy got %b want 0", busy4);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        drive(0, 1'b1, 8'h0B, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (outs(0) !== 6'b0) $display("FAIL reset_mid got %b want 000000", outs(0));
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t < 4 + CE + 3; t++) begin
            n_checks++;
            if ({busy4, done4} !== 2'b00)
                $display("FAIL reset_mid_quiet t=%0d got %b want 00", t, {busy4, done4});
            else n_pass++;
            @(negedge clk);
        end
        $display("reset mid-load: no done observed");
        run_load(0, 8'h06, 1'b1, 1'b0);
    endtask

`ifdef SHIFT_SEQ_CHECK_EN
    task automatic test_check;
        zero_q = 1'b1;
        run_load(0, 8'h0B, 1'b0, 1'b1);
        zero_q = 1'b0;
        run_load(0, 8'h0B, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        reset = 1'b1; zero_q = 1'b0;
        start4 = 1'b0; word4 = 4'h0; order4 = 1'b0;
        start8 = 1'b0; word8 = 8'h00; order8 = 1'b0;
        test_reset;
        test_basic;
        test_n8;
        test_random;
        test_back_to_back;
        test_reset_mid;
`ifdef SHIFT_SEQ_CHECK_EN
        test_check;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
